// File: rtl/asynchronous_fifo_pkg.sv
// asynchronous_fifo_pkg: shared default geometry for the FIFO and its storage.
package asynchronous_fifo_pkg;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_WIDTH_DEF = 3;
endpackage

// File: rtl/asynchronous_fifo_mem.sv
// fifo_mem: DEPTH x DATA_WIDTH storage, synchronous write, registered read, no reset.
// Ports: clk_i clock; we_i/waddr_i/wdata_i write port; re_i/raddr_i read request; rdata_o registered word.
module fifo_mem
    import asynchronous_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end
    assign rdata_o = rdata_q;
endmodule

// File: rtl/asynchronous_fifo.sv
// asynchronous_fifo: single-clock FIFO with binary wrap-bit pointers and registered read data.
// Ports: w_clk clock; w_rst sync active-high reset; w_en/w_data write; r_en read request;
//        r_data read word (one edge latency); full/empty occupancy flags.
module asynchronous_fifo
    import asynchronous_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  w_clk,
    input  logic                  w_rst,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  r_en,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  full,
    output logic                  empty
);
    localparam int PW = ADDR_WIDTH + 1;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic rd_seen_q, rd_seen_d;
    logic w_acc, r_acc;
    logic [DATA_WIDTH-1:0] mem_rdata;
    assign empty = wr_ptr_q == rd_ptr_q;
    assign full  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                   (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
    assign w_acc = w_en && !full && !w_rst;
    assign r_acc = r_en && !empty && !w_rst;
    always_comb begin
        wr_ptr_d  = w_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = r_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
        rd_seen_d = rd_seen_q || r_acc;
    end
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_seen_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_seen_q <= rd_seen_d;
        end
    end
    // The storage read register has no reset, so r_data reads as zero until
    // the first read accepted since reset has loaded it.
    assign r_data = rd_seen_q ? mem_rdata : '0;
    fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_mem (
        .clk_i   (w_clk),
        .we_i    (w_acc),
        .waddr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wdata_i (w_data),
        .re_i    (r_acc),
        .raddr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rdata_o (mem_rdata)
    );
endmodule

// File: tb/tb_asynchronous_fifo.sv
// tb_asynchronous_fifo: directed vector table plus hand sequences for the FIFO corner cases.
module tb_asynchronous_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       w_en = 1'b0;
    logic       r_en = 1'b0;
    logic [7:0] w_data = 8'h00;
    logic [7:0] r_data;
    logic       full, empty;
    int         passed = 0;
    int         total = 0;

    typedef struct {
        logic       we;
        logic       re;
        logic [7:0] wd;
        logic [7:0] rd;
        logic       f;
        logic       e;
    } vec_t;
    vec_t v[18];

    always #5 clk = ~clk;

    asynchronous_fifo dut (
        .w_clk  (clk),
        .w_rst  (rst),
        .w_en   (w_en),
        .w_data (w_data),
        .r_en   (r_en),
        .r_data (r_data),
        .full   (full),
        .empty  (empty)
    );

    task automatic step(input logic we, input logic re, input logic [7:0] wd, input logic r);
        w_en = we;
        r_en = re;
        w_data = wd;
        rst = r;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input logic [7:0] rd, input logic f, input logic e);
        total++;
        if ({r_data, full, empty} !== {rd, f, e})
            $display("FAIL %s: got r_data=%h full=%b empty=%b, want r_data=%h full=%b empty=%b",
                     n, r_data, full, empty, rd, f, e);
        else
            passed++;
    endtask

    initial begin
        logic [7:0] d;
        for (int i = 0; i < 9; i++) begin
            d = 8'(8'h11 * (i + 1));
            v[i] = '{1'b1, 1'b0, d, 8'h00, i >= 7, 1'b0};
        end
        for (int i = 0; i < 9; i++) begin
            d = 8'(8'h11 * (i < 8 ? i + 1 : 8));
            v[9 + i] = '{1'b0, 1'b1, 8'h00, d, 1'b0, i >= 7};
        end

        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 8'hEE, 1'b1);
        chk("reset", 8'h00, 1'b0, 1'b1);

        for (int i = 0; i < 18; i++) begin
            step(v[i].we, v[i].re, v[i].wd, 1'b0);
            chk($sformatf("vec%0d", i), v[i].rd, v[i].f, v[i].e);
        end

        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'hB0 + i), 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("wrap_pre", 8'hB4, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 8'(8'hA0 + i), 1'b0);
            chk($sformatf("wrap_w%0d", i), 8'hB4, i == 7, 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 8'h00, 1'b0);
            chk($sformatf("wrap_r%0d", i), 8'(8'hA0 + i), 1'b0, i == 7);
        end

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'hC0 + i), 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 8'(8'hD0 + i), 1'b0);
            chk($sformatf("simul%0d", i), i < 3 ? 8'(8'hC0 + i) : 8'(8'hD0 + i - 3), 1'b0, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 8'h00, 1'b0);
            chk($sformatf("simul_drain%0d", i), 8'(8'hD7 + i), 1'b0, i == 2);
        end

        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'hE0 + i), 1'b0);
        chk("full_pre", 8'hD9, 1'b1, 1'b0);
        step(1'b1, 1'b1, 8'hFF, 1'b0);
        chk("full_both", 8'hE0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("full_both_drain", 8'hE7, 1'b0, 1'b1);

        step(1'b1, 1'b1, 8'h77, 1'b0);
        chk("empty_both", 8'hE7, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("empty_both_read", 8'h77, 1'b0, 1'b1);

        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'h31 + i), 1'b0);
        step(1'b1, 1'b1, 8'h99, 1'b1);
        chk("midrst", 8'h00, 1'b0, 1'b1);
        step(1'b1, 1'b0, 8'h5A, 1'b0);
        chk("midrst_w", 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("midrst_r", 8'h5A, 1'b0, 1'b1);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("midrst_hold", 8'h5A, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/asynchronous_fifo.md
ASYNCHRONOUS_FIFO -- requirements
Module: asynchronous_fifo

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter: DATA_WIDTH, default 8, width of each stored word.
REQ-003 Parameter: ADDR_WIDTH, default 3, log2 of depth (DEPTH = 2**ADDR_WIDTH = 8 words).
REQ-004 Port: w_clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port: w_rst  input  1  synchronous active-high reset.
REQ-006 Port: w_en  input  1  write request.
REQ-007 Port: w_data  input  DATA_WIDTH  write data, sampled on an accepted write.
REQ-008 Port: r_en  input  1  read request.
REQ-009 Port: r_data  output  DATA_WIDTH  registered read data.
REQ-010 Port: full  output  1  high when DEPTH words are stored.
REQ-011 Port: empty  output  1  high when zero words are stored.

Function
REQ-012 SHALL accept a write when w_en=1 and full=0: store w_data at write pointer, increment write pointer.
REQ-013 SHALL ignore w_en while full=1: no storage change, no pointer change.
REQ-014 SHALL accept a read when r_en=1 and empty=0: load r_data with the word at read pointer on that edge, increment read pointer.
REQ-015 SHALL hold r_data unchanged when no read is accepted, including r_en=1 while empty.
REQ-016 Read latency SHALL be one edge: word visible on r_data immediately after the accepting edge.
REQ-017 Pointers SHALL be ADDR_WIDTH+1 bits binary; low ADDR_WIDTH bits address memory; wrap from DEPTH-1 to 0 with MSB toggle.
REQ-018 empty SHALL be high when read and write pointers are equal (all bits).
REQ-019 full SHALL be high when pointers differ only in MSB (low bits equal).
REQ-020 full and empty SHALL be combinational decodes of registered pointers, valid in the cycle after the updating edge.
REQ-021 Simultaneous accepted read and write SHALL both occur on the same edge; occupancy unchanged.
REQ-022 When full with w_en=1 and r_en=1: read accepted, write rejected; full deasserts next cycle.
REQ-023 When empty with w_en=1 and r_en=1: write accepted, read rejected; no write-through bypass to r_data.
REQ-024 Data SHALL emerge in exact write order (FIFO), no loss or duplication across wrap-around.

Reset
REQ-025 While w_rst=1 at a rising edge: both pointers to 0, r_data to 0, empty=1, full=0; w_en/r_en ignored.
REQ-026 Memory contents SHALL NOT require reset; stale words are unreachable after reset.
REQ-027 Reset asserted mid-operation SHALL discard all stored words; first post-reset read returns first post-reset write.

Structure
REQ-028 Shared package SHALL hold default DATA_WIDTH (8) and ADDR_WIDTH (3) constants; pointer width derived locally as ADDR_WIDTH+1.
REQ-029 One sub-module fifo_mem SHALL implement the DEPTH x DATA_WIDTH storage: synchronous write port, registered read port, no reset.
REQ-030 Pointer/flag logic SHALL reside in the top module.

Verification
REQ-031 Reset: w_rst=1 for 5 edges -> empty=1, full=0, r_data=0x00.
REQ-032 Fill: write 8 words 0x11..0x88 with r_en=0 -> full=1 after the 8th edge; 9th write 0x99 ignored.
REQ-033 Drain: from full, r_en=1 for 9 edges -> r_data sequence 0x11..0x88, empty=1 after 8th read, r_data holds 0x88 on 9th.
REQ-034 Wrap: write 5, read 5, write 8 (0xA0..0xA7), read 8 -> reads return 0xA0..0xA7 in order; full asserted once at 8 stored.
REQ-035 Simultaneous: with 3 stored, w_en=r_en=1 for 10 edges -> occupancy stays 3, empty and full never assert, order preserved.
REQ-036 Mid-operation reset: 4 stored, assert w_rst one edge -> empty=1; then write 0x5A, read -> r_data=0x5A.
